// File: rtl/aes_inv_keysched.sv
// AES-128 decryption key scheduler: expands the cipher key forward to round 10, then
// streams round keys 10..0 by running the key schedule backwards, one key per handshake.

module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse is x^254 (= x^2 * x^4 * ... * x^128), which maps 0 to 0 as required.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int k = 0; k < 7; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   assign out_o = sbox(in_i);
endmodule

module aes_inv_keysched #(
   parameter int NROUNDS = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_round,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done
);
   localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

   typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

   state_t       state_q;
   logic [127:0] key_q;
   logic [3:0]   cnt_q;
   logic         valid_q;
   logic         done_q;

   logic [31:0]  k0, k1, k2, k3;
   logic [31:0]  sub_in, sub_rot, sub_out, mix;
   logic [7:0]   rcon;
   logic [127:0] key_fwd_d, key_inv_d;

   assign {k0, k1, k2, k3} = key_q;

   always_comb begin
      case (cnt_q)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   // One S-box row serves both directions: forward uses w3, inverse recovers w3 as w7^w6.
   assign sub_in  = (state_q == EXPAND) ? k3 : (k3 ^ k2);
   assign sub_rot = {sub_in[23:0], sub_in[31:24]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sbox
         aes_sbox u_sbox (
            .in_i  (sub_rot[8*gi +: 8]),
            .out_o (sub_out[8*gi +: 8])
         );
      end
   endgenerate

   assign mix = sub_out ^ {rcon, 24'h000000};

   always_comb begin
      key_fwd_d[127:96] = k0 ^ mix;
      key_fwd_d[95:64]  = k1 ^ key_fwd_d[127:96];
      key_fwd_d[63:32]  = k2 ^ key_fwd_d[95:64];
      key_fwd_d[31:0]   = k3 ^ key_fwd_d[63:32];
      key_inv_d         = {k0 ^ mix, k1 ^ k0, k2 ^ k1, k3 ^ k2};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         key_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  key_q   <= key_in;
                  cnt_q   <= 4'd1;
                  state_q <= EXPAND;
               end
            end
            EXPAND: begin
               key_q <= key_fwd_d;
               if (cnt_q == LAST_ROUND) begin
                  state_q <= STREAM;
                  valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            STREAM: begin
               if (rk_ready) begin
                  if (cnt_q == 4'd0) begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     key_q <= key_inv_d;
                     cnt_q <= cnt_q - 4'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rk_data  = key_q;
   assign rk_round = cnt_q;
   assign rk_valid = valid_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
endmodule
